// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, frame shift-out on device clock edges,
// acknowledge check and overall frame timeout, with done/error pulses to user logic.
//
// state   | meaning
// IDLE    | ready for a byte, both lines released
// INHIBIT | SCL held low for the request-to-send window
// RTS     | SCL and SDA both driven low for one cycle (start bit)
// SEND    | data, parity and stop bits driven on SCL falling edges
// ACK     | waiting for the device acknowledge slot
// RELEASE | waiting for the device to release both lines
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [7:0] TX_data,
    input  logic       TX_valid,
    output logic       TX_ready,
    output logic       TX_done,
    output logic       TX_error,
    input  logic       SDA,
    input  logic       SCL,
    output logic       SDA_oe,
    output logic       SCL_oe
);

    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IW-1:0] INHIBIT_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        RELEASE
    } state_t;

    state_t        state, state_nx;
    logic [1:0]    sda_s, scl_s;
    logic [9:0]    frame, frame_nx;
    logic [IW-1:0] count, count_nx;
    logic [TW-1:0] timeout, timeout_nx;
    logic [3:0]    bitcnt, bitcnt_nx;
    logic          nack, nack_nx;
    logic          sda_oe_nx, scl_oe_nx;
    logic          ready_nx, done_nx, error_nx;
    logic          scl_fall;

    // older sample in bit 1, newest in bit 0
    assign scl_fall = (scl_s == 2'b10);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state    <= IDLE;
            sda_s    <= 2'b11;
            scl_s    <= 2'b11;
            frame    <= '0;
            count    <= '0;
            timeout  <= '0;
            bitcnt   <= '0;
            nack     <= 1'b0;
            SDA_oe   <= 1'b0;
            SCL_oe   <= 1'b0;
            TX_ready <= 1'b1;
            TX_done  <= 1'b0;
            TX_error <= 1'b0;
        end else begin
            state    <= state_nx;
            sda_s    <= {sda_s[0], SDA};
            scl_s    <= {scl_s[0], SCL};
            frame    <= frame_nx;
            count    <= count_nx;
            timeout  <= timeout_nx;
            bitcnt   <= bitcnt_nx;
            nack     <= nack_nx;
            SDA_oe   <= sda_oe_nx;
            SCL_oe   <= scl_oe_nx;
            TX_ready <= ready_nx;
            TX_done  <= done_nx;
            TX_error <= error_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        frame_nx   = frame;
        count_nx   = count;
        timeout_nx = timeout;
        bitcnt_nx  = bitcnt;
        nack_nx    = nack;
        sda_oe_nx  = SDA_oe;
        scl_oe_nx  = SCL_oe;
        ready_nx   = TX_ready;
        done_nx    = 1'b0;
        error_nx   = 1'b0;

        case (state)
            IDLE: begin
                sda_oe_nx = 1'b0;
                scl_oe_nx = 1'b0;
                if (TX_valid && TX_ready) begin
                    frame_nx  = {1'b1, ~^TX_data, TX_data};
                    ready_nx  = 1'b0;
                    scl_oe_nx = 1'b1;
                    count_nx  = '0;
                    state_nx  = INHIBIT;
                end
            end

            INHIBIT: begin
                scl_oe_nx = 1'b1;
                count_nx  = count + 1'b1;
                if (count == INHIBIT_LAST) begin
                    sda_oe_nx = 1'b1;
                    state_nx  = RTS;
                end
            end

            RTS: begin
                scl_oe_nx  = 1'b0;
                bitcnt_nx  = '0;
                timeout_nx = '0;
                nack_nx    = 1'b0;
                state_nx   = SEND;
            end

            SEND, ACK, RELEASE: begin
                // a stuck device must not hold the transmitter forever; this wins over any edge
                if (timeout == TIMEOUT_LAST) begin
                    sda_oe_nx = 1'b0;
                    scl_oe_nx = 1'b0;
                    error_nx  = 1'b1;
                    ready_nx  = 1'b1;
                    state_nx  = IDLE;
                end else begin
                    timeout_nx = timeout + 1'b1;
                    if (state == SEND) begin
                        if (scl_fall) begin
                            sda_oe_nx = ~frame[0];
                            frame_nx  = {1'b0, frame[9:1]};
                            bitcnt_nx = bitcnt + 1'b1;
                            if (bitcnt == 4'd9) begin
                                state_nx = ACK;
                            end
                        end
                    end else if (state == ACK) begin
                        if (scl_fall) begin
                            nack_nx  = sda_s[1];
                            state_nx = RELEASE;
                        end
                    end else begin
                        if (scl_s[1] && sda_s[1]) begin
                            done_nx  = ~nack;
                            error_nx = nack;
                            ready_nx = 1'b1;
                            state_nx = IDLE;
                        end
                    end
                end
            end

            default: begin
                sda_oe_nx = 1'b0;
                scl_oe_nx = 1'b0;
                ready_nx  = 1'b1;
                state_nx  = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model, behavioural PS/2 device, and a queue of
// expected bytes/outcomes checked against what the device captures and the pulses seen.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 2000;
    localparam int HALF = 20;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] TX_data = 8'h00;
    logic       TX_valid = 1'b0;
    logic       TX_ready, TX_done, TX_error;
    logic       SDA, SCL, SDA_oe, SCL_oe;
    logic       dev_scl_low = 1'b0;
    logic       dev_sda_low = 1'b0;

    assign SDA = ~(SDA_oe | dev_sda_low);
    assign SCL = ~(SCL_oe | dev_scl_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .TX_data  (TX_data),
        .TX_valid (TX_valid),
        .TX_ready (TX_ready),
        .TX_done  (TX_done),
        .TX_error (TX_error),
        .SDA      (SDA),
        .SCL      (SCL),
        .SDA_oe   (SDA_oe),
        .SCL_oe   (SCL_oe)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [7:0] data;
        logic       ack;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_bad = 0;
    int ready_bad = 0;
    int idle_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge CLOCK) begin
        if (TX_done) done_cnt <= done_cnt + 1;
        if (TX_error) err_cnt <= err_cnt + 1;
        if (TX_done && TX_error) both_bad <= both_bad + 1;
        if ((TX_done || TX_error) && !TX_ready) ready_bad <= ready_bad + 1;
        if (TX_ready && (SDA_oe || SCL_oe)) idle_bad <= idle_bad + 1;
    end

    task automatic send(input logic [7:0] d, input logic ack);
        exp_t e;
        int n;
        n = 0;
        while (!TX_ready && n < 500) begin
            @(negedge CLOCK);
            n++;
        end
        check_val("send_ready", TX_ready, 1);
        TX_data  = d;
        TX_valid = 1'b1;
        e.data = d;
        e.ack  = ack;
        exp_q.push_back(e);
        @(negedge CLOCK);
        TX_valid = 1'b0;
        TX_data  = ~d;
        check_val("accept_ready_low", TX_ready, 0);
    endtask

    // device: waits for start condition, clocks 10 bits sampling on rising edges, then ack slot
    task automatic dev_frame(input logic ack, input int rst_bit,
                             output logic [9:0] bits, output logic ok);
        int n;
        bits = '0;
        ok   = 1'b0;
        n    = 0;
        while (!(SCL === 1'b1 && SDA === 1'b0) && n < 200) begin
            @(negedge CLOCK);
            n++;
        end
        check_val("start_seen", n < 200, 1);
        if (n >= 200) return;
        repeat (10) @(negedge CLOCK);
        for (int i = 0; i < 10; i++) begin
            dev_scl_low = 1'b1;
            repeat (HALF) @(negedge CLOCK);
            if (i == rst_bit) begin
                RESET = 1'b1;
                @(negedge CLOCK);
                RESET = 1'b0;
                check_val("rst_sda_oe", SDA_oe, 0);
                check_val("rst_scl_oe", SCL_oe, 0);
                check_val("rst_ready", TX_ready, 1);
                check_val("rst_no_pulse", {TX_done, TX_error}, 0);
                dev_scl_low = 1'b0;
                return;
            end
            bits[i] = SDA;
            dev_scl_low = 1'b0;
            repeat (HALF) @(negedge CLOCK);
        end
        dev_sda_low = ack;
        repeat (5) @(negedge CLOCK);
        dev_scl_low = 1'b1;
        repeat (HALF) @(negedge CLOCK);
        dev_scl_low = 1'b0;
        repeat (HALF) @(negedge CLOCK);
        dev_sda_low = 1'b0;
        ok = 1'b1;
    endtask

    task automatic sb_compare(input logic [9:0] bits, input int d_delta, input int e_delta);
        exp_t e;
        check_val("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check_val("frame_bits", bits, {1'b1, ~^e.data, e.data});
        check_val("done_pulses", d_delta, e.ack ? 1 : 0);
        check_val("error_pulses", e_delta, e.ack ? 0 : 1);
        check_val("ready_after", TX_ready, 1);
    endtask

    task automatic xfer(input logic [7:0] d, input logic ack, input logic measure);
        int d0, e0, n;
        logic [9:0] bits;
        logic ok;
        d0 = done_cnt;
        e0 = err_cnt;
        send(d, ack);
        if (measure) begin
            n = 0;
            while (SCL_oe && !SDA_oe && n < 100) begin
                @(negedge CLOCK);
                n++;
            end
            check_val("inhibit_len", n, INH);
            check_val("rts_lines", {SCL_oe, SDA_oe}, 2'b11);
        end
        dev_frame(ack, -1, bits, ok);
        n = 0;
        while ((done_cnt + err_cnt) == (d0 + e0) && n < 200) begin
            @(negedge CLOCK);
            n++;
        end
        repeat (5) @(negedge CLOCK);
        sb_compare(bits, done_cnt - d0, err_cnt - e0);
    endtask

    initial begin
        int d0, e0, n;
        logic [9:0] bits;
        logic ok;
        exp_t e;

        repeat (3) @(negedge CLOCK);
        check_val("reset_sda_oe", SDA_oe, 0);
        check_val("reset_scl_oe", SCL_oe, 0);
        check_val("reset_ready", TX_ready, 1);
        check_val("reset_done", TX_done, 0);
        check_val("reset_error", TX_error, 0);
        RESET = 1'b0;
        repeat (3) @(negedge CLOCK);

        xfer(8'hA5, 1'b1, 1'b1);
        xfer(8'h07, 1'b1, 1'b0);
        xfer(8'h00, 1'b1, 1'b0);
        xfer(8'h5A, 1'b0, 1'b0);

        // timeout: device never clocks
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h81, 1'b0);
        n = 0;
        while (!(SCL === 1'b1 && SDA === 1'b0) && n < 200) begin
            @(negedge CLOCK);
            n++;
        end
        check_val("to_release_seen", n < 200, 1);
        n = 0;
        while (!TX_error && n < TMO + 500) begin
            @(negedge CLOCK);
            n++;
        end
        check_val("to_latency", n, TMO);
        check_val("to_lines", {SDA_oe, SCL_oe}, 2'b00);
        check_val("to_ready", TX_ready, 1);
        repeat (5) @(negedge CLOCK);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check_val("to_done_pulses", done_cnt - d0, 0);
        check_val("to_error_pulses", err_cnt - e0, 1);

        // reset in the middle of bit 4, then a clean frame
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h96, 1'b1);
        dev_frame(1'b1, 4, bits, ok);
        repeat (50) @(negedge CLOCK);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check_val("rst_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
        check_val("rst_ready_hold", TX_ready, 1);
        xfer(8'h3C, 1'b1, 1'b0);

        // request while busy must be dropped
        d0 = done_cnt;
        fork
            xfer(8'h12, 1'b1, 1'b0);
            begin
                repeat (100) @(negedge CLOCK);
                TX_valid = 1'b1;
                TX_data  = 8'hFF;
                @(negedge CLOCK);
                TX_valid = 1'b0;
            end
        join
        repeat (100) @(negedge CLOCK);
        check_val("busy_done_once", done_cnt - d0, 1);
        check_val("busy_not_queued", TX_ready, 1);
        check_val("busy_scl_idle", SCL_oe, 0);
        check_val("sb_drained", exp_q.size(), 0);

        check_val("done_error_overlap", both_bad, 0);
        check_val("pulse_without_ready", ready_bad, 0);
        check_val("lines_driven_idle", idle_bad, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte (e.g. keyboard LED/reset commands) to a PS/2 device over the shared open-drain SCL/SDA pair.
- Pairs with the existing PS/2 receiver that shares the same two lines.
- Performs the request-to-send sequence, shifts out data, parity and stop bits on device-generated clock edges, and checks the device acknowledge bit.
- Reports completion or error to the user logic through single-cycle pulses.

Parameters:
- INHIBIT_CYCLES, 5000, CLOCK cycles SCL is held low for request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 50000, CLOCK cycles allowed from releasing SCL until the frame completes.

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- TX_data  in  8  byte to send; sampled on accept.
- TX_valid  in  1  send request; accepted when TX_valid && TX_ready.
- TX_ready  out  1  high when idle and able to accept a byte.
- TX_done  out  1  one-cycle pulse: byte sent and acknowledged.
- TX_error  out  1  one-cycle pulse: NACK or timeout.
- SDA  in  1  sensed PS/2 data line (asynchronous).
- SCL  in  1  sensed PS/2 clock line (asynchronous).
- SDA_oe  out  1  1 = drive SDA low; 0 = release.
- SCL_oe  out  1  1 = drive SCL low; 0 = release.

Behaviour:
- Reset values:
  - SDA_oe=0, SCL_oe=0, TX_ready=1, TX_done=0, TX_error=0.
  - state=IDLE; counters 0; synchronizers 2'b11.
  - RESET mid-frame releases both lines on the next edge; no done or error pulse is issued.
- Synchronizers and edge detect:
  - SDA and SCL each pass through a 2-bit shift register (sda_s, scl_s).
  - A falling edge of SCL is detected when scl_s==2'b10.
  - Every decision uses synchronized values only.
- Counters: widths are $clog2 of their parameter.
- IDLE:
  - TX_ready=1.
  - On accept: latch frame = {1'b1 stop, ~^TX_data odd parity, TX_data}, which is 10 bits sent LSB first.
  - Also on accept: TX_ready<=0, SCL_oe<=1, count<=0, state goes to INHIBIT.
- INHIBIT:
  - SCL_oe held 1; count increments each cycle.
  - When count==INHIBIT_CYCLES-1: SDA_oe<=1 (start bit) and state goes to RTS.
- RTS: one cycle with both lines driven. Then SCL_oe<=0, bitcnt<=0, timeout<=0, state goes to SEND.
- SEND:
  - On each SCL falling edge: SDA_oe<=~frame[0], frame shifts right, bitcnt++.
  - After the 10th edge (stop bit, SDA_oe=0), state goes to ACK.
- ACK:
  - On the next SCL falling edge, sample sda_s: 0 means ACK, 1 means NACK (nack flag set).
  - State goes to RELEASE.
- RELEASE:
  - Wait until scl_s[1]==1 and sda_s[1]==1.
  - Then pulse TX_done (ACK) or TX_error (NACK) for one cycle, TX_ready<=1, state goes to IDLE.
- Timeout:
  - Counts every cycle in SEND, ACK and RELEASE.
  - At TIMEOUT_CYCLES: SDA_oe<=0, SCL_oe<=0, TX_error pulses once, state goes to IDLE.
  - Timeout has priority over a simultaneous edge.
- Accept rules:
  - TX_valid while TX_ready=0 is ignored and not queued.
  - TX_data changes after accept have no effect.
- Pulse timing:
  - TX_done and TX_error are never high together.
  - TX_ready rises in the same cycle as the pulse; a new accept is allowed the following cycle.
- Line activity: SCL_oe is 1 only in INHIBIT and RTS. SDA_oe is never 1 in IDLE.

Test Plan:
(bench uses INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000, and a device model clocking at a 40-cycle period)
- Send 0xA5 with device ACK -> SCL low exactly 20 cycles, then start bit. Device samples 1,0,1,0,0,1,0,1, parity 1, stop 1. TX_done pulses once, TX_ready returns to 1.
- Send 0x07 -> device samples parity 0. Send 0x00 -> parity 1. Both end with TX_done.
- Device drives SDA high in the ACK slot -> TX_error pulses once after lines are released, TX_done stays 0.
- Device never clocks after RTS -> exactly 2000 cycles after SCL release, TX_error pulses, SDA_oe=SCL_oe=0, TX_ready=1.
- Assert RESET during bit 4 -> next cycle SDA_oe=SCL_oe=0, TX_ready=1, no pulse. A following 0x3C send completes correctly.
- Pulse TX_valid with 0xFF during a 0x12 transfer -> ignored. Device receives only 0x12, and TX_done pulses once.
